mac_arbiter: RTL and testbench
==============================

MAC_ARBITER -- requirements
Module: mac_arbiter

Interface
REQ-001 Parameter WIDTH, 32, operand/result width in bits.
REQ-002 Parameter TIMEOUT, 8, cycles allowed in WAIT for mac_valido (used only with MAC_ARB_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state changes on posedge clk.
REQ-004 rst_  in  1  reset, synchronous, active-low.
REQ-005 req0_valid  in  1  requester 0 holds an operand set.
REQ-006 req0_ready  out  1  requester 0 operand set accepted this cycle.
REQ-007 req0_a, req0_b, req0_c  in  WIDTH each  requester 0 operands.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_c  as REQ-005..007 for requester 1.
REQ-009 mac_validi  out  1  drives datapath validi.
REQ-010 mac_data_in  out  WIDTH  drives datapath data_in.
REQ-011 mac_valido  in  1  datapath valido.
REQ-012 mac_data_out  in  WIDTH  datapath data_out (a*b+c).
REQ-013 rsp_valid  out  1  result available; rsp_ready  in  1  consumer accepts.
REQ-014 rsp_id  out  1  requester that owns the result; rsp_data  out  WIDTH  result; rsp_err  out  1  timeout flag.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, OP_A, OP_B, OP_C, WAIT, RESP.
REQ-017 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally for that cycle only, latch a/b/c and grant id, go OP_A.
REQ-018 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; with one valid, grant it.
REQ-019 Round-robin pointer SHALL update only on RESP handshake (rsp_valid & rsp_ready).
REQ-020 OP_A/OP_B/OP_C: mac_validi=1, mac_data_in = latched a/b/c respectively, one cycle each, then advance.
REQ-021 Outside OP_A..OP_C: mac_validi=0, mac_data_in=0.
REQ-022 WAIT: on mac_valido=1 capture mac_data_out into rsp_data, rsp_err=0, go RESP.
REQ-023 mac_valido in any state other than WAIT SHALL be ignored.
REQ-024 RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_err stable until rsp_ready=1; then IDLE next cycle.
REQ-025 Latency: accept at cycle T, validi T+1..T+3, valido expected T+4, rsp_valid from T+5; minimum 6 cycles per operation.
REQ-026 Both reqN_ready SHALL be 0 in every state except IDLE; never both 1.
REQ-027 Result arithmetic is the datapath's; expected value a*b+c modulo 2^WIDTH.

Reset
REQ-028 rst_=0 at a posedge SHALL force IDLE; pointer set so requester 0 wins the first tie.
REQ-029 Reset values: req0_ready=0, req1_ready=0, mac_validi=0, mac_data_in=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0.
REQ-030 Reset mid-operation SHALL abandon the operation with no response; mac_validi=0 from the next cycle.

Configuration
REQ-031 Macro MAC_ARB_TIMEOUT_EN defined: WAIT counts cycles; after TIMEOUT cycles without mac_valido go RESP with rsp_err=1, rsp_data=0; counter clears on WAIT entry.
REQ-032 Macro undefined: WAIT holds indefinitely; rsp_err constant 0; no counter logic.

Verification
REQ-033 req0 a=3,b=4,c=5 only -> data_in 3,4,5 on T+1..T+3, rsp_valid T+5, rsp_data=17, rsp_id=0.
REQ-034 req0 and req1 valid together after reset (req1 a=2,b=6,c=1) -> req0 served first (17), then req1 (13, rsp_id=1).
REQ-035 a=0xFFFFFFFF,b=2,c=3 -> rsp_data=0x00000001.
REQ-036 rsp_ready held 0 for 3 cycles in RESP -> rsp_valid, rsp_id, rsp_data unchanged; no new ready.
REQ-037 rst_=0 during OP_B -> mac_validi=0 next cycle, busy=0, no rsp_valid.
REQ-038 MAC_ARB_TIMEOUT_EN, TIMEOUT=8, mac_valido forced 0 -> RESP after 8 WAIT cycles, rsp_err=1, rsp_data=0.

Source files
------------

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one a*b+c datapath between two requesters.
// Define MAC_ARB_TIMEOUT_EN to bound the WAIT state by TIMEOUT cycles.
module mac_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req0_c,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [WIDTH-1:0] req1_c,
  output logic             mac_validi,
  output logic [WIDTH-1:0] mac_data_in,
  input  logic             mac_valido,
  input  logic [WIDTH-1:0] mac_data_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_err,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request, grants one
  // OP_A  | a on mac_data_in
  // OP_B  | b on mac_data_in
  // OP_C  | c on mac_data_in
  // WAIT  | waiting for mac_valido
  // RESP  | result held until rsp_ready
  typedef enum logic [2:0] {IDLE, OP_A, OP_B, OP_C, WAIT, RESP} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_rsp_data;
  logic             r_id, r_pref1;
  logic             w_accept, w_gnt1, w_tmo;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mac_arbiter: TIMEOUT must be at least 1");
  end

  // r_pref1 names the requester that wins a tie; it moves only on a completed response.
  assign w_gnt1     = req1_valid && (!req0_valid || r_pref1);
  assign w_accept   = rst_ && (r_state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = w_accept && !w_gnt1;
  assign req1_ready = w_accept && w_gnt1;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_id;
  assign rsp_data   = r_rsp_data;
  assign busy       = (r_state != IDLE);

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_rsp_err;

  // Loaded while in OP_C so the count starts fresh on every WAIT entry.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_tmo_cnt <= '0;
    end else if (r_state == OP_C) begin
      r_tmo_cnt <= TW'(TIMEOUT - 1);
    end else if ((r_state == WAIT) && (r_tmo_cnt != '0)) begin
      r_tmo_cnt <= r_tmo_cnt - 1'b1;
    end
  end

  assign w_tmo   = (r_state == WAIT) && !mac_valido && (r_tmo_cnt == '0);
  assign rsp_err = r_rsp_err;
`else
  assign w_tmo   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    w_next      = r_state;
    mac_validi  = 1'b0;
    mac_data_in = '0;
    case (r_state)
      IDLE: if (w_accept) w_next = OP_A;
      OP_A: begin
        mac_validi  = 1'b1;
        mac_data_in = r_a;
        w_next      = OP_B;
      end
      OP_B: begin
        mac_validi  = 1'b1;
        mac_data_in = r_b;
        w_next      = OP_C;
      end
      OP_C: begin
        mac_validi  = 1'b1;
        mac_data_in = r_c;
        w_next      = WAIT;
      end
      WAIT: if (mac_valido || w_tmo) w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      r_state    <= IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_id       <= 1'b0;
      r_pref1    <= 1'b0;
      r_rsp_data <= '0;
`ifdef MAC_ARB_TIMEOUT_EN
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_a  <= w_gnt1 ? req1_a : req0_a;
        r_b  <= w_gnt1 ? req1_b : req0_b;
        r_c  <= w_gnt1 ? req1_c : req0_c;
        r_id <= w_gnt1;
      end
      if ((r_state == WAIT) && mac_valido) begin
        r_rsp_data <= mac_data_out;
`ifdef MAC_ARB_TIMEOUT_EN
        r_rsp_err  <= 1'b0;
      end else if (w_tmo) begin
        r_rsp_data <= '0;
        r_rsp_err  <= 1'b1;
`endif
      end
      if ((r_state == RESP) && rsp_ready) r_pref1 <= ~r_id;
    end
  end

endmodule

// File: tb/tb_mac_arbiter.sv
// Self-checking bench for mac_arbiter: directed cases plus randomized traffic
// against a transaction-level model (round-robin winner, a*b+c mod 2^WIDTH).
module tb_mac_arbiter;
  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  logic             clk = 1'b0;
  logic             rst_;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic             mac_validi, mac_valido;
  logic [WIDTH-1:0] mac_data_in, mac_data_out;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  always #5 clk = ~clk;

  mac_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_(rst_),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .mac_validi(mac_validi), .mac_data_in(mac_data_in),
    .mac_valido(mac_valido), .mac_data_out(mac_data_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: pending operand sets per requester and the tie winner.
  int               m_prefer;
  bit               op_v [2];
  logic [WIDTH-1:0] op_a [2];
  logic [WIDTH-1:0] op_b [2];
  logic [WIDTH-1:0] op_c [2];
  logic [WIDTH-1:0] last_data;
  logic             last_id;

  function automatic logic [WIDTH-1:0] ref_mac(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] c);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b} + {{WIDTH{1'b0}}, c};
    return full[WIDTH-1:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_reqs();
    req0_valid = op_v[0];
    req0_a = op_a[0]; req0_b = op_b[0]; req0_c = op_c[0];
    req1_valid = op_v[1];
    req1_a = op_a[1]; req1_b = op_b[1]; req1_c = op_c[1];
  endtask

  task automatic set_op(input int r, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] c);
    op_v[r] = 1'b1;
    op_a[r] = a; op_b[r] = b; op_c[r] = c;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    op_v[0] = 1'b0; op_v[1] = 1'b0;
    drive_reqs();
    mac_valido = 1'b0; mac_data_out = '0; rsp_ready = 1'b0;
    tick(); tick();
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_mac_validi", mac_validi, 0);
    chk("rst_mac_data_in", mac_data_in, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_busy", busy, 0);
    rst_ = 1'b1;
    m_prefer = 0;
    tick();
  endtask

  // One full transaction from IDLE; the bench plays the datapath role.
  task automatic serve_one(input int extra_wait, input int hold, input bit spurious);
    int               g;
    logic [WIDTH-1:0] ea, eb, ec, exp;
    logic [WIDTH-1:0] cap [3];
    g  = (op_v[0] && op_v[1]) ? m_prefer : (op_v[0] ? 0 : 1);
    ea = op_a[g]; eb = op_b[g]; ec = op_c[g];
    exp = ref_mac(ea, eb, ec);
    drive_reqs();
    #1;
    chk("accept_ready0", req0_ready, g == 0);
    chk("accept_ready1", req1_ready, g == 1);
    chk("accept_busy", busy, 0);
    tick();
    op_v[g] = 1'b0;
    drive_reqs();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("op_validi", mac_validi, 1);
      chk("op_data_in", mac_data_in, (k == 0) ? ea : ((k == 1) ? eb : ec));
      chk("op_readies", {req0_ready, req1_ready}, 0);
      chk("op_busy", busy, 1);
      cap[k] = mac_data_in;
      if (spurious && k == 1) begin
        mac_valido = 1'b1; mac_data_out = $urandom;
      end
      tick();
      mac_valido = 1'b0;
    end
    for (int w = 0; w < extra_wait; w++) begin
      #1;
      chk("wait_validi", mac_validi, 0);
      chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_readies", {req0_ready, req1_ready}, 0);
      chk("wait_busy", busy, 1);
      tick();
    end
    mac_valido = 1'b1;
    mac_data_out = WIDTH'(cap[0] * cap[1] + cap[2]);
    #1;
    chk("wait_data_in", mac_data_in, 0);
    chk("wait_rsp_valid", rsp_valid, 0);
    tick();
    mac_valido = 1'b0;
    mac_data_out = $urandom;
    for (int h = 0; h < hold; h++) begin
      rsp_ready = 1'b0;
      #1;
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_id", rsp_id, g);
      chk("hold_rsp_data", rsp_data, exp);
      chk("hold_rsp_err", rsp_err, 0);
      chk("hold_readies", {req0_ready, req1_ready}, 0);
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    chk("resp_valid", rsp_valid, 1);
    chk("resp_id", rsp_id, g);
    chk("resp_data", rsp_data, exp);
    chk("resp_err", rsp_err, 0);
    last_data = rsp_data;
    last_id   = rsp_id;
    tick();
    rsp_ready = 1'b0;
    m_prefer = 1 - g;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_rsp_valid", rsp_valid, 0);
  endtask

  initial begin
    int r;
    rst_ = 1'b0;
    op_v[0] = 1'b0; op_v[1] = 1'b0;
    op_a[0] = '0; op_b[0] = '0; op_c[0] = '0;
    op_a[1] = '0; op_b[1] = '0; op_c[1] = '0;
    drive_reqs();
    mac_valido = 1'b0; mac_data_out = '0; rsp_ready = 1'b0;
    @(negedge clk);
    do_reset();

    set_op(0, 3, 4, 5);
    serve_one(0, 0, 0);
    chk("single_req0_data", last_data, 17);
    chk("single_req0_id", last_id, 0);

    do_reset();
    set_op(0, 3, 4, 5);
    set_op(1, 2, 6, 1);
    serve_one(0, 0, 0);
    chk("tie_first_data", last_data, 17);
    chk("tie_first_id", last_id, 0);
    serve_one(0, 0, 0);
    chk("tie_second_data", last_data, 13);
    chk("tie_second_id", last_id, 1);

    set_op(0, 32'hFFFF_FFFF, 2, 3);
    serve_one(0, 0, 0);
    chk("wrap_data", last_data, 32'h0000_0001);

    set_op(1, 7, 9, 11);
    set_op(0, 1, 1, 1);
    serve_one(1, 3, 1);
    chk("hold_then_accept_data", last_data, 74);
    serve_one(0, 0, 0);

    for (int n = 0; n < 40; n++) begin
      for (int q = 0; q < 2; q++) begin
        if (!op_v[q] && ($urandom_range(0, 1) == 1))
          set_op(q, (n % 8 == 0) ? '1 : WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      end
      if (!op_v[0] && !op_v[1]) begin
        r = int'($urandom_range(0, 1));
        set_op(r, WIDTH'($urandom), WIDTH'($urandom), WIDTH'($urandom));
      end
      serve_one(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    do_reset();
    set_op(0, 5, 5, 5);
    drive_reqs();
    tick();
    op_v[0] = 1'b0;
    drive_reqs();
    tick();
    #1;
    chk("midrst_in_op_b", mac_validi, 1);
    rst_ = 1'b0;
    tick();
    #1;
    chk("midrst_validi", mac_validi, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    rst_ = 1'b1;
    m_prefer = 0;
    mac_valido = 1'b1; mac_data_out = 32'h1234;
    tick();
    mac_valido = 1'b0;
    #1;
    chk("midrst_after_busy", busy, 0);
    chk("midrst_after_rsp_valid", rsp_valid, 0);
    set_op(0, 10, 10, 10);
    set_op(1, 20, 20, 20);
    serve_one(0, 0, 0);
    chk("midrst_tie_id", last_id, 0);
    serve_one(0, 0, 0);
    chk("midrst_second_data", last_data, 420);

`ifdef MAC_ARB_TIMEOUT_EN
    set_op(1, 6, 7, 8);
    drive_reqs();
    #1;
    chk("tmo_accept_ready1", req1_ready, 1);
    tick();
    op_v[1] = 1'b0;
    drive_reqs();
    tick(); tick(); tick();
    for (int w = 0; w < TIMEOUT; w++) begin
      mac_data_out = $urandom;
      #1;
      chk("tmo_wait_rsp_valid", rsp_valid, 0);
      chk("tmo_wait_busy", busy, 1);
      tick();
    end
    #1;
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    chk("tmo_rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    m_prefer = 0;
    set_op(0, 2, 3, 4);
    serve_one(TIMEOUT - 1, 0, 0);
    chk("tmo_last_cycle_data", last_data, 10);
`else
    set_op(1, 6, 7, 8);
    serve_one(20, 1, 0);
    chk("long_wait_data", last_data, 50);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
